mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter for a single shared main-memory port.
// Define ARB_ROUND_ROBIN_EN to alternate grants on ties; otherwise D always wins ties.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_done,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [15:0]       i_grant_cnt,
  output logic [15:0]       d_grant_cnt
);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

  state_t            state_reg, state_next;
  logic [LINE_W-1:0] i_rdata_reg, d_rdata_reg;
  logic [15:0]       i_cnt_reg, d_cnt_reg;
  logic              grant_d;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers which side won the last grant; 0 = I, 1 = D.
  logic last_d_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_d_reg <= 1'b0;
    end else if (state_reg == IDLE && state_next == BUSY_D) begin
      last_d_reg <= 1'b1;
    end else if (state_reg == IDLE && state_next == BUSY_I) begin
      last_d_reg <= 1'b0;
    end
  end

  assign grant_d = d_req && !(i_req && last_d_reg);
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_d) begin
          state_next = BUSY_D;
        end else if (i_req) begin
          state_next = BUSY_I;
        end
      end
      BUSY_I: begin
        mem_req  = 1'b1;
        mem_addr = i_addr;
        if (mem_ready) begin
          state_next = RESP_I;
        end
      end
      BUSY_D: begin
        mem_req   = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        if (mem_ready) begin
          state_next = RESP_D;
        end
      end
      RESP_I: begin
        i_done     = 1'b1;
        state_next = IDLE;
      end
      RESP_D: begin
        d_done     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Read data is captured on completion and held until that side completes again.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      i_rdata_reg <= '0;
      d_rdata_reg <= '0;
    end else begin
      if (state_reg == BUSY_I && mem_ready) begin
        i_rdata_reg <= mem_rdata;
      end
      if (state_reg == BUSY_D && mem_ready) begin
        d_rdata_reg <= d_we ? '0 : mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      i_cnt_reg <= '0;
      d_cnt_reg <= '0;
    end else begin
      if (state_reg == BUSY_I && mem_ready && i_cnt_reg != 16'hFFFF) begin
        i_cnt_reg <= i_cnt_reg + 16'd1;
      end
      if (state_reg == BUSY_D && mem_ready && d_cnt_reg != 16'hFFFF) begin
        d_cnt_reg <= d_cnt_reg + 16'd1;
      end
    end
  end

  assign i_rdata     = i_rdata_reg;
  assign d_rdata     = d_rdata_reg;
  assign i_grant_cnt = i_cnt_reg;
  assign d_grant_cnt = d_cnt_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: a table of single-transaction vectors
// plus hand-written sequences for back-to-back ties, reset abort and saturation.
module tb_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req, i_done;
  logic [15:0] i_addr;
  logic [63:0] i_rdata;
  logic        d_req, d_we, d_done;
  logic [15:0] d_addr;
  logic [63:0] d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [15:0] i_grant_cnt, d_grant_cnt;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .LINE_W(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  // Memory model: answers mem_req after mem_lat extra cycles; data chosen by address.
  logic        auto_en, auto_ready, man_ready;
  logic [63:0] auto_rdata, cur_rd_i, cur_rd_d;
  logic [15:0] cur_i_addr;
  int          mem_lat;
  int          busy_cnt;

  assign mem_ready = auto_ready | man_ready;
  assign mem_rdata = auto_ready ? auto_rdata : 64'h0BAD_0BAD_0BAD_0BAD;

  initial begin
    auto_ready = 1'b0;
    auto_rdata = '0;
    busy_cnt   = 0;
  end

  always @(negedge clk) begin
    auto_ready = 1'b0;
    if (auto_en && mem_req) begin
      if (busy_cnt == mem_lat) begin
        auto_ready = 1'b1;
        auto_rdata = (mem_addr == cur_i_addr) ? cur_rd_i : cur_rd_d;
        busy_cnt   = 0;
      end else begin
        busy_cnt = busy_cnt + 1;
      end
    end else begin
      busy_cnt = 0;
    end
  end

  typedef struct packed {
    logic        i_go;
    logic [15:0] i_addr;
    logic [63:0] rd_i;
    logic        d_go;
    logic        d_we;
    logic [15:0] d_addr;
    logic [63:0] d_wdata;
    logic [63:0] rd_d;
    logic [3:0]  lat;
    logic        exp_d_first;
    logic        exp_we_first;
    logic [15:0] exp_addr_first;
    logic [63:0] exp_wdata_first;
    logic [63:0] exp_i_rdata;
    logic [63:0] exp_d_rdata;
  } vec_t;

  vec_t        vecs [6];
  vec_t        sat_vec;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] exp_i_cnt, exp_d_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    man_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_i_cnt = '0;
    exp_d_cnt = '0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit first_seen;
    bit i_pend, d_pend;
    int first_done;
    cur_i_addr = v.i_addr; cur_rd_i = v.rd_i; cur_rd_d = v.rd_d;
    mem_lat    = int'(v.lat);
    @(negedge clk);
    i_req = v.i_go; i_addr = v.i_addr;
    d_req = v.d_go; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    first_seen = 1'b0; first_done = -1;
    i_pend = v.i_go; d_pend = v.d_go;
    for (int c = 0; c < 60 && (i_pend || d_pend); c++) begin
      @(negedge clk);
      if (mem_req && !first_seen) begin
        first_seen = 1'b1;
        check($sformatf("v%0d grant_latency", idx), 64'(c), 64'd0);
        check($sformatf("v%0d first_addr", idx), 64'(mem_addr), 64'(v.exp_addr_first));
        check($sformatf("v%0d first_we", idx), 64'(mem_we), 64'(v.exp_we_first));
        check($sformatf("v%0d first_wdata", idx), mem_wdata, v.exp_wdata_first);
      end
      if (i_done) begin
        if (first_done < 0) first_done = 0;
        i_pend = 1'b0; i_req = 1'b0;
        exp_i_cnt = sat_inc(exp_i_cnt);
        check($sformatf("v%0d i_rdata", idx), i_rdata, v.exp_i_rdata);
      end
      if (d_done) begin
        if (first_done < 0) first_done = 1;
        d_pend = 1'b0; d_req = 1'b0;
        exp_d_cnt = sat_inc(exp_d_cnt);
        check($sformatf("v%0d d_rdata", idx), d_rdata, v.exp_d_rdata);
      end
    end
    check($sformatf("v%0d pending_at_timeout", idx), 64'(i_pend | d_pend), 64'd0);
    check($sformatf("v%0d first_done_owner", idx), 64'(first_done), 64'(v.exp_d_first));
    @(negedge clk);
    check($sformatf("v%0d done_pulse_width", idx), 64'(i_done | d_done), 64'd0);
    check($sformatf("v%0d i_grant_cnt", idx), 64'(i_grant_cnt), 64'(exp_i_cnt));
    check($sformatf("v%0d d_grant_cnt", idx), 64'(d_grant_cnt), 64'(exp_d_cnt));
    $display("vector %0d: i_go=%0b d_go=%0b d_we=%0b lat=%0d first=%0d i_cnt=%0d d_cnt=%0d",
             idx, v.i_go, v.d_go, v.d_we, v.lat, first_done, i_grant_cnt, d_grant_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ng;
    logic [3:0]  grants;
    bit          seen;

    vecs[0] = '{1'b1, 16'h0040, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 16'h0000, 64'h0, 64'h0, 4'd2,
                1'b0, 1'b0, 16'h0040, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h0};
    vecs[1] = '{1'b1, 16'h0100, 64'h1111_2222_3333_4444, 1'b1, 1'b1, 16'h0080, 64'hFFFF_0000_FFFF_0000,
                64'h9999_9999_9999_9999, 4'd1,
                1'b1, 1'b1, 16'h0080, 64'hFFFF_0000_FFFF_0000, 64'h1111_2222_3333_4444, 64'h0};
    vecs[2] = '{1'b0, 16'h0100, 64'h0, 1'b1, 1'b0, 16'h0200, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 4'd0,
                1'b1, 1'b0, 16'h0200, 64'h0, 64'h0, 64'hDEAD_BEEF_CAFE_F00D};
    vecs[3] = '{1'b1, 16'h0400, 64'h0A0A_0A0A_0A0A_0A0A, 1'b1, 1'b0, 16'h0300, 64'h0,
                64'h0D0D_0D0D_0D0D_0D0D, 4'd3,
                !RR, 1'b0, (RR ? 16'h0400 : 16'h0300), 64'h0, 64'h0A0A_0A0A_0A0A_0A0A,
                64'h0D0D_0D0D_0D0D_0D0D};
    vecs[4] = '{1'b1, 16'hFFFF, 64'h8000_0000_0000_0001, 1'b0, 1'b1, 16'h0700, 64'hAAAA_AAAA_AAAA_AAAA,
                64'h0, 4'd0,
                1'b0, 1'b0, 16'hFFFF, 64'h0, 64'h8000_0000_0000_0001, 64'h0};
    vecs[5] = '{1'b0, 16'h0040, 64'h0, 1'b1, 1'b1, 16'h0000, 64'h0123_4567_89AB_CDEF,
                64'hFFFF_FFFF_FFFF_FFFF, 4'd1,
                1'b1, 1'b1, 16'h0000, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0};
    sat_vec = '{1'b0, 16'h0040, 64'h0, 1'b1, 1'b0, 16'h0600, 64'h0, 64'h5A5A_5A5A_5A5A_5A5A, 4'd0,
                1'b1, 1'b0, 16'h0600, 64'h0, 64'h0, 64'h5A5A_5A5A_5A5A_5A5A};

    auto_en = 1'b1; man_ready = 1'b0; mem_lat = 0;
    cur_i_addr = '0; cur_rd_i = '0; cur_rd_d = '0;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst mem_req", 64'(mem_req), 64'd0);
    check("rst mem_we", 64'(mem_we), 64'd0);
    check("rst mem_addr", 64'(mem_addr), 64'd0);
    check("rst mem_wdata", mem_wdata, 64'd0);
    check("rst dones", 64'({i_done, d_done}), 64'd0);
    check("rst i_rdata", i_rdata, 64'd0);
    check("rst d_rdata", d_rdata, 64'd0);
    check("rst counters", 64'({i_grant_cnt, d_grant_cnt}), 64'd0);
    $display("reset: mem_req=%0b i_cnt=%0d d_cnt=%0d", mem_req, i_grant_cnt, d_grant_cnt);

    // mem_ready while idle must be ignored
    man_ready = 1'b1;
    @(negedge clk);
    man_ready = 1'b0;
    @(negedge clk);
    check("idle_ready dones", 64'({i_done, d_done}), 64'd0);
    check("idle_ready mem_req", 64'(mem_req), 64'd0);
    check("idle_ready counters", 64'({i_grant_cnt, d_grant_cnt}), 64'd0);
    check("idle_ready rdata", i_rdata | d_rdata, 64'd0);
    $display("idle mem_ready: dones=%0b%0b mem_req=%0b", i_done, d_done, mem_req);

    for (int k = 0; k < 6; k++) begin
      run_vec(k, vecs[k]);
    end

    // Both sides request continuously for four grants
    do_reset();
    cur_i_addr = 16'h0800; cur_rd_i = 64'h1; cur_rd_d = 64'h2; mem_lat = 0;
    @(negedge clk);
    i_req = 1'b1; i_addr = 16'h0800;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0900; d_wdata = '0;
    ng = 0; grants = '0;
    for (int c = 0; c < 80 && ng < 4; c++) begin
      @(negedge clk);
      if (d_done) begin
        grants[ng] = 1'b1; ng++;
      end else if (i_done) begin
        grants[ng] = 1'b0; ng++;
      end
      if (ng == 4) begin
        i_req = 1'b0; d_req = 1'b0;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    check("tie grants_seen", 64'(ng), 64'd4);
    check("tie grant_order", 64'(grants), RR ? 64'b0101 : 64'b1111);
    @(negedge clk);
    check("tie i_grant_cnt", 64'(i_grant_cnt), RR ? 64'd2 : 64'd0);
    check("tie d_grant_cnt", 64'(d_grant_cnt), RR ? 64'd2 : 64'd4);
    $display("tie: grants(bit k: 1=D)=%b i_cnt=%0d d_cnt=%0d", grants, i_grant_cnt, d_grant_cnt);
    repeat (2) @(negedge clk);

    // Reset while BUSY_D with mem_ready in the same cycle
    auto_en = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0500; d_wdata = '0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = mem_req;
    end
    check("abort busy_reached", 64'(seen), 64'd1);
    reset_n = 1'b0; man_ready = 1'b1; d_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; man_ready = 1'b0;
    check("abort d_done", 64'(d_done), 64'd0);
    check("abort mem_req", 64'(mem_req), 64'd0);
    check("abort d_grant_cnt", 64'(d_grant_cnt), 64'd0);
    check("abort d_rdata", d_rdata, 64'd0);
    @(negedge clk);
    check("abort late d_done", 64'(d_done), 64'd0);
    $display("abort: d_done=%0b mem_req=%0b d_cnt=%0d", d_done, mem_req, d_grant_cnt);
    exp_i_cnt = '0; exp_d_cnt = '0;
    auto_en = 1'b1;

    // Saturation from a preloaded D counter
    force dut.d_cnt_reg = 16'hFFFE;
    @(negedge clk);
    release dut.d_cnt_reg;
    exp_d_cnt = 16'hFFFE;
    for (int k = 0; k < 3; k++) begin
      run_vec(10 + k, sat_vec);
      check($sformatf("sat%0d d_grant_cnt", k), 64'(d_grant_cnt), 64'hFFFF);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
